// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with data and control buses.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 8,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic [CTRL_W-1:0] main_c;
  logic [CTRL_W-1:0] skid_c;
  logic [1:0]        occ;

  logic acc;
  logic xfer;
  logic main_v_n;
  logic skid_v_n;
  logic ld_in;
  logic ld_skid;
  logic skid_ld;

  always_comb begin
    if (SKID) begin
      in_ready = ~skid_v & ~stall & ~flush;
    end else begin
      in_ready = (~main_v | out_ready) & ~stall & ~flush;
    end
  end

  assign acc  = in_valid & in_ready;
  assign xfer = main_v & out_ready & ~stall;

  // skid drains first; in_ready is low then, so no accept can collide
  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    ld_in    = 1'b0;
    ld_skid  = 1'b0;
    skid_ld  = 1'b0;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (!stall) begin
      if (SKID && skid_v && xfer) begin
        ld_skid  = 1'b1;
        skid_v_n = 1'b0;
      end else if (acc && (!main_v || xfer || !SKID)) begin
        ld_in    = 1'b1;
        main_v_n = 1'b1;
      end else if (acc) begin
        skid_ld  = 1'b1;
        skid_v_n = 1'b1;
      end else if (xfer) begin
        main_v_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      main_c <= '0;
      skid_d <= '0;
      skid_c <= '0;
      occ    <= 2'd0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      occ    <= {1'b0, main_v_n} + {1'b0, skid_v_n};
      if (ld_in) begin
        main_d <= in_data;
        main_c <= in_ctrl;
      end else if (ld_skid) begin
        main_d <= skid_d;
        main_c <= skid_c;
      end
      if (skid_ld) begin
        skid_d <= in_data;
        skid_c <= in_ctrl;
      end
    end
  end

  // bubbles never carry stale enables downstream
  assign out_valid = main_v;
  assign out_data  = main_v ? main_d : '0;
  assign out_ctrl  = main_v ? main_c : '0;
  assign occupancy = occ;

endmodule
